subsurf_host: RTL
=================

SUBSURF_HOST -- requirements
Module: subsurf_host

Interface
REQ-001 SHALL have parameter START_CYCLES, default 3: number of cycles sub_start is held high.
REQ-002 SHALL have parameter DEPTH, default 512: RAM depth in 32-bit words, with a 9-bit address.
REQ-003 SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- go  in  1  starts one load/compute/drain job when the block is idle.
- in_valid, in_data, in_last  in  1/32/1  mesh word stream into the object RAM.
- in_ready  out  1  stream accept.
- out_valid, out_data, out_last  out  1/32/1  result word stream.
- out_ready  in  1  downstream accept.
- res_words  in  10  number of result words to drain, sampled on entry to DRAIN.
- sub_start  out  1  start to the subdivision engine.
- sub_busy  in  1  busy from the subdivision engine.
- en, a, we, di  out  1/9/4/32  host RAM port (externally muxed).
- do  in  32  host RAM read data, valid 1 cycle after en with we=0.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse when a job completes.
- err  out  1  sticky load overflow flag.
- wait_cycles  out  32  engine runtime counter (see Configuration).

Function
REQ-004 SHALL implement the FSM states IDLE, LOAD, KICK, WAIT, DRAIN.
REQ-005 In IDLE, go=1 SHALL clear err and the write address and move to LOAD; go SHALL be ignored in all other states.
REQ-006 In LOAD, in_ready SHALL be 1; each in_valid&&in_ready SHALL write in_data with en=1, we=4'hF, a=addr, and then increment addr.
REQ-007 An accepted word with in_last=1 SHALL end LOAD and move to KICK on the next cycle.
REQ-008 An accepted word at addr=DEPTH-1 with in_last=0 SHALL set err=1 and return to IDLE without a done pulse and without asserting sub_start.
REQ-009 KICK SHALL hold sub_start=1 for exactly START_CYCLES cycles and then move to WAIT with sub_start=0.
REQ-010 WAIT SHALL ignore sub_busy in its first cycle; from the second cycle on, sub_busy=0 SHALL move the FSM to DRAIN.
REQ-011 On entry to DRAIN the block SHALL latch res_words; a latched value of 0 SHALL pulse done and return to IDLE within 1 cycle.
REQ-012 DRAIN SHALL read addresses 0..res_words-1 in order through a 2-entry output buffer.
REQ-013 A read SHALL be issued only when (buffered words + reads in flight) < 2, so no word is ever dropped under out_ready backpressure.
REQ-014 The first out_valid SHALL occur 2 cycles after DRAIN entry when out_ready=1; with out_ready held at 1, throughput SHALL be 1 word/cycle.
REQ-015 out_data and out_last SHALL be stable while out_valid=1 and out_ready=0; out_last SHALL be 1 only on word res_words-1.
REQ-016 Acceptance of the last word SHALL pulse done for 1 cycle and return the FSM to IDLE.
REQ-017 When the block is not in LOAD or DRAIN, en, a, we and di SHALL be 0; in_ready=0 and out_valid=0 outside LOAD and DRAIN respectively.
REQ-018 The address counter SHALL be 9 bits; a res_words value > DEPTH SHALL be saturated to DEPTH.

Reset
REQ-019 While rst_n=0, the FSM SHALL be IDLE and all outputs SHALL be 0, including busy, done, err, sub_start, en, we and wait_cycles.
REQ-020 Reset asserted mid-job SHALL abort the job immediately and discard the output buffer; after release, the block SHALL act only on a fresh go.

Configuration
REQ-021 With SUBSURF_HOST_CYCLE_COUNT_EN defined, wait_cycles SHALL be cleared on KICK entry, increment every cycle in KICK and WAIT, and hold its value until the next KICK.
REQ-022 Without SUBSURF_HOST_CYCLE_COUNT_EN, wait_cycles SHALL be tied to 0 and no counter logic SHALL be generated.

Verification
REQ-023 go; 4 words 0x11,0x22,0x33,0x44 (last on the 4th); sub_busy low 10 cycles after KICK; res_words=4; out_ready=1 -> RAM writes at a=0..3, sub_start high 3 cycles, 4 reads then out words = RAM contents at 0..3, out_last on the 4th word, 1 done pulse.
REQ-024 512 words with no in_last -> err=1 after the 512th accept, FSM in IDLE, sub_start never asserted, done=0.
REQ-025 Drain of res_words=6 with out_ready toggling 1,0,0,1,... -> all 6 words delivered once each in order, data stable while stalled, never more than 2 reads outstanding.
REQ-026 res_words=0 -> done pulse within 1 cycle of DRAIN entry, out_valid never asserted.
REQ-027 rst_n pulled low mid-DRAIN, then go reissued -> outputs zero during reset; the new job completes normally with no stale words.
REQ-028 With SUBSURF_HOST_CYCLE_COUNT_EN defined and sub_busy dropping at WAIT cycle 20 -> wait_cycles=23 after the job completes; without the macro -> wait_cycles=0 throughout.

Source files
------------

// File: rtl/subsurf_host.sv
// Host sequencer for the subdivision engine: load mesh words into RAM, kick the engine,
// wait for it, then drain results. SUBSURF_HOST_CYCLE_COUNT_EN enables wait_cycles.
// RAM read data comes in on ram_do ("do" is a reserved word).
module subsurf_host #(
  parameter int START_CYCLES = 3,
  parameter int DEPTH        = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  input  logic [9:0]  res_words,
  output logic        sub_start,
  input  logic        sub_busy,
  output logic        en,
  output logic [8:0]  a,
  output logic [3:0]  we,
  output logic [31:0] di,
  input  logic [31:0] ram_do,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] wait_cycles
);

  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT, DRAIN} state_t;
  state_t state, nstate;

  localparam logic [15:0] KICK_LAST = 16'(START_CYCLES - 1);
  localparam logic [8:0]  ADDR_LAST = 9'(DEPTH - 1);
  localparam logic [9:0]  RW_MAX    = 10'(DEPTH);

  logic [8:0]  addr;
  logic [15:0] kcnt;
  logic        wait_first;
  logic [9:0]  rw, rcnt, ocnt, rw_sat;
  logic        rd_vld, rd_issue, pop;
  logic [1:0]  bcnt;
  logic [31:0] obuf [2];
  logic        wptr, rptr;
  logic [2:0]  occ;

  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN) && (bcnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (ocnt == rw - 10'd1);
  assign out_data  = obuf[rptr];
  assign rw_sat    = (res_words > RW_MAX) ? RW_MAX : res_words;
  // A word leaving this cycle frees its slot, so a read may be issued in its place.
  assign occ       = {1'b0, bcnt} + {2'b0, rd_vld} - {2'b0, pop};

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    en        = 1'b0;
    a         = '0;
    we        = '0;
    di        = '0;
    sub_start = 1'b0;
    done      = 1'b0;
    rd_issue  = 1'b0;
    case (state)
      IDLE: if (go) nstate = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          en = 1'b1;
          we = 4'hF;
          a  = addr;
          di = in_data;
          if (in_last)                nstate = KICK;
          else if (addr == ADDR_LAST) nstate = IDLE;
        end
      end
      KICK: begin
        sub_start = 1'b1;
        if (kcnt == KICK_LAST) nstate = WAIT;
      end
      WAIT: if (!wait_first && !sub_busy) nstate = DRAIN;
      DRAIN: begin
        rd_issue = (rcnt < rw) && (occ < 3'd2);
        en       = rd_issue;
        a        = rd_issue ? rcnt[8:0] : 9'd0;
        if (rw == 10'd0 || (pop && out_last)) begin
          done   = 1'b1;
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      err        <= 1'b0;
      kcnt       <= '0;
      wait_first <= 1'b0;
    end else begin
      state      <= nstate;
      wait_first <= (state != WAIT);
      kcnt       <= (state == KICK) ? kcnt + 16'd1 : 16'd0;
      if (state == IDLE && go) begin
        addr <= '0;
        err  <= 1'b0;
      end else if (state == LOAD && in_valid) begin
        addr <= addr + 9'd1;
        if (!in_last && addr == ADDR_LAST) err <= 1'b1;
      end
    end
  end

  // Drain datapath: read issue count, one-cycle read pipe, 2-entry output buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw      <= '0;
      rcnt    <= '0;
      ocnt    <= '0;
      rd_vld  <= 1'b0;
      bcnt    <= '0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      obuf[0] <= '0;
      obuf[1] <= '0;
    end else if (state == WAIT && nstate == DRAIN) begin
      rw     <= rw_sat;
      rcnt   <= '0;
      ocnt   <= '0;
      rd_vld <= 1'b0;
      bcnt   <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
    end else if (state == DRAIN) begin
      rd_vld <= rd_issue;
      if (rd_issue) rcnt <= rcnt + 10'd1;
      if (rd_vld) begin
        obuf[wptr] <= ram_do;
        wptr       <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
        ocnt <= ocnt + 10'd1;
      end
      bcnt <= bcnt + {1'b0, rd_vld} - {1'b0, pop};
    end
  end

`ifdef SUBSURF_HOST_CYCLE_COUNT_EN
  logic [31:0] wcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                wcnt <= '0;
    else if (nstate == KICK && state != KICK)  wcnt <= '0;
    else if (state == KICK || state == WAIT)   wcnt <= wcnt + 32'd1;
  end
  assign wait_cycles = wcnt;
`else
  assign wait_cycles = '0;
`endif

endmodule
